// File: rtl/audio_play_sched_if.sv
// Sample-source handshake bundle shared by the mic-loopback and tone-player
// sources feeding the playback scheduler.
interface audio_play_sched_if;
    logic        req0_valid;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_data;
    logic        req1_ready;

    // Source side: offers samples, observes acceptance.
    modport master (
        output req0_valid, req0_data,
        input  req0_ready,
        output req1_valid, req1_data,
        input  req1_ready
    );

    // Scheduler side: samples offers, issues acceptance.
    modport slave (
        input  req0_valid, req0_data,
        output req0_ready,
        input  req1_valid, req1_data,
        output req1_ready
    );
endinterface

// File: rtl/audio_play_sched.sv
// Playback scheduler: shares one 16-bit PWM serializer between two sample
// sources. Generates bit/frame timing, takes one sample per frame using
// round-robin arbitration, and sequences amplifier power (wake, idle sleep,
// disable).
module audio_play_sched #(
    parameter int unsigned DIV         = 64,
    parameter int unsigned IDLE_FRAMES = 8,
    parameter int unsigned WAKE_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    audio_play_sched_if.slave  req,
    output logic               bit_tick,
    output logic               ser_load,
    output logic [15:0]        ser_data,
    output logic               amp_sd,
    output logic               active_src,
    output logic               underrun
);

    localparam int unsigned DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (IDLE_FRAMES > 1) ? $clog2(IDLE_FRAMES + 1) : 1;
    localparam int unsigned WW = (WAKE_FRAMES > 1) ? $clog2(WAKE_FRAMES + 1) : 1;

    localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(IDLE_FRAMES);
    localparam logic [WW-1:0] WMAX = WW'(WAKE_FRAMES);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAKE,
        ST_RUN,
        ST_SLEEP
    } state_t;

    state_t        state, state_d;
    logic [DW-1:0] dcnt;
    logic [3:0]    bcnt;
    logic          frame_start;
    logic          last_grant, last_d;
    logic [IW-1:0] idle_cnt, idle_d, idle_inc;
    logic [WW-1:0] wake_cnt, wake_d, wake_inc;
    logic          amp_d, load_d, src_d;
    logic [15:0]   data_d;
    logic          any_valid, grant1;

    assign bit_tick    = (state != ST_OFF) && (dcnt == DMAX);
    assign frame_start = bit_tick && (bcnt == 4'd15);

    // Bit divider and bit-in-frame counter; parked at zero while powered off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dcnt <= '0;
            bcnt <= '0;
        end else if (state == ST_OFF) begin
            dcnt <= '0;
            bcnt <= '0;
        end else begin
            dcnt <= bit_tick ? '0 : dcnt + DW'(1);
            if (bit_tick) begin
                bcnt <= bcnt + 4'd1;
            end
        end
    end

    // Next-state, arbitration and frame-start decisions.
    always_comb begin
        state_d        = state;
        amp_d          = amp_sd;
        load_d         = 1'b0;
        data_d         = ser_data;
        src_d          = active_src;
        last_d         = last_grant;
        idle_d         = idle_cnt;
        wake_d         = wake_cnt;
        req.req0_ready = 1'b0;
        req.req1_ready = 1'b0;
        underrun       = 1'b0;
        idle_inc       = idle_cnt + IW'(1);
        wake_inc       = wake_cnt + WW'(1);
        any_valid      = req.req0_valid || req.req1_valid;
        // On a tie the source that did not win last time takes the frame.
        grant1         = (req.req0_valid && req.req1_valid) ? ~last_grant : req.req1_valid;

        if (state == ST_OFF) begin
            if (enable) begin
                state_d = ST_WAKE;
                amp_d   = 1'b1;
                wake_d  = '0;
                idle_d  = '0;
            end
        end else if (frame_start) begin
            if (!enable) begin
                // Shutdown takes effect only at a frame boundary so the
                // frame in flight is never truncated.
                state_d = ST_OFF;
                amp_d   = 1'b0;
            end else begin
                case (state)
                    ST_WAKE: begin
                        load_d = 1'b1;
                        data_d = '0;
                        wake_d = wake_inc;
                        if (wake_inc == WMAX) begin
                            state_d = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        load_d = 1'b1;
                        if (any_valid) begin
                            idle_d = '0;
                            src_d  = grant1;
                            last_d = grant1;
                            if (grant1) begin
                                req.req1_ready = 1'b1;
                                data_d         = req.req1_data;
                            end else begin
                                req.req0_ready = 1'b1;
                                data_d         = req.req0_data;
                            end
                        end else begin
                            underrun = 1'b1;
                            data_d   = '0;
                            idle_d   = idle_inc;
                            if (idle_inc == IMAX) begin
                                state_d = ST_SLEEP;
                                amp_d   = 1'b0;
                            end
                        end
                    end
                    ST_SLEEP: begin
                        if (any_valid) begin
                            state_d = ST_WAKE;
                            amp_d   = 1'b1;
                            wake_d  = '0;
                            idle_d  = '0;
                        end
                    end
                    default: begin
                        state_d = ST_OFF;
                    end
                endcase
            end
        end
    end

    // State, serializer outputs and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_OFF;
            amp_sd     <= 1'b0;
            ser_load   <= 1'b0;
            ser_data   <= '0;
            active_src <= 1'b0;
            last_grant <= 1'b1;
            idle_cnt   <= '0;
            wake_cnt   <= '0;
        end else begin
            state      <= state_d;
            amp_sd     <= amp_d;
            ser_load   <= load_d;
            ser_data   <= data_d;
            active_src <= src_d;
            last_grant <= last_d;
            idle_cnt   <= idle_d;
            wake_cnt   <= wake_d;
        end
    end

endmodule

// File: tb/tb_audio_play_sched.sv
// Bench for audio_play_sched: frame-level vector table, directed disable and
// reset sequences, then randomized traffic against a cycle-counting model.
module tb_audio_play_sched;

    localparam int DIV   = 4;
    localparam int IDLE  = 3;
    localparam int WAKE  = 2;
    localparam int FRAME = 16 * DIV;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic        bit_tick, ser_load, amp_sd, active_src, underrun;
    logic [15:0] ser_data;

    audio_play_sched_if bus ();

    audio_play_sched #(
        .DIV         (DIV),
        .IDLE_FRAMES (IDLE),
        .WAKE_FRAMES (WAKE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req        (bus.slave),
        .bit_tick   (bit_tick),
        .ser_load   (ser_load),
        .ser_data   (ser_data),
        .amp_sd     (amp_sd),
        .active_src (active_src),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_load_cyc = 0;
    int load_gap      = 0;

    // ---------------- reference model ----------------
    typedef enum int {M_OFF, M_WAKE, M_RUN, M_SLEEP} mode_t;
    mode_t       m_mode;
    int          m_t;        // cycles since the frame clock started
    bit          m_amp, m_load, m_src, m_last;
    logic [15:0] m_data;
    int          m_idle, m_wake;
    bit          p_bt, p_fs, p_r0, p_r1, p_ur;

    task automatic model_reset();
        m_mode = M_OFF; m_t = 0; m_amp = 0; m_load = 0; m_data = '0;
        m_src = 0; m_last = 1; m_idle = 0; m_wake = 0;
    endtask

    task automatic predict();
        bit run;
        run  = (m_mode != M_OFF);
        p_bt = run && ((m_t % DIV) == DIV - 1);
        p_fs = run && ((m_t % FRAME) == FRAME - 1);
        p_r0 = 0; p_r1 = 0; p_ur = 0;
        if (p_fs && enable && m_mode == M_RUN) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (m_last) p_r0 = 1; else p_r1 = 1;
            end else if (bus.req0_valid) p_r0 = 1;
            else if (bus.req1_valid)     p_r1 = 1;
            else                         p_ur = 1;
        end
    endtask

    task automatic model_clock();
        m_load = 0;
        if (m_mode == M_OFF) begin
            if (enable) begin
                m_mode = M_WAKE; m_amp = 1; m_wake = 0; m_idle = 0; m_t = 0;
            end
        end else if (p_fs && !enable) begin
            m_mode = M_OFF; m_amp = 0; m_t = 0;
        end else begin
            m_t++;
            if (p_fs) begin
                case (m_mode)
                    M_WAKE: begin
                        m_load = 1; m_data = '0; m_wake++;
                        if (m_wake == WAKE) m_mode = M_RUN;
                    end
                    M_RUN: begin
                        m_load = 1;
                        if (p_r0) begin
                            m_data = bus.req0_data; m_src = 0; m_last = 0; m_idle = 0;
                        end else if (p_r1) begin
                            m_data = bus.req1_data; m_src = 1; m_last = 1; m_idle = 0;
                        end else begin
                            m_data = '0; m_idle++;
                            if (m_idle == IDLE) begin m_mode = M_SLEEP; m_amp = 0; end
                        end
                    end
                    M_SLEEP: begin
                        if (bus.req0_valid || bus.req1_valid) begin
                            m_mode = M_WAKE; m_amp = 1; m_wake = 0; m_idle = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Called at posedge+1; compares every output with the model mid-cycle.
    task automatic sample();
        #2;
        predict();
        check("outputs",
              32'({bit_tick, ser_load, ser_data, amp_sd, active_src, underrun,
                   bus.req0_ready, bus.req1_ready}),
              32'({p_bt, m_load, m_data, m_amp, m_src, p_ur, p_r0, p_r1}));
        if (ser_load === 1'b1) begin
            load_gap      = cyc - last_load_cyc;
            last_load_cyc = cyc;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset === 1'b1) model_clock();
        cyc++;
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    // ---------------- frame vector table ----------------
    typedef struct {
        bit          en, v0;
        logic [15:0] d0;
        bit          v1;
        logic [15:0] d1;
        bit          r0, r1, ur, ld;
        logic [15:0] data;
        bit          src, amp, gap;
    } vec_t;

    function automatic vec_t mk(bit en, bit v0, logic [15:0] d0, bit v1, logic [15:0] d1,
                                bit r0, bit r1, bit ur, bit ld, logic [15:0] data,
                                bit src, bit amp, bit gap);
        vec_t v;
        v.en = en; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.ur = ur; v.ld = ld; v.data = data;
        v.src = src; v.amp = amp; v.gap = gap;
        return v;
    endfunction

    // Apply inputs, run to the next frame start, check the handshake there
    // and the serializer outputs one clock later.
    task automatic run_frame(input vec_t v, input string tag);
        enable         = v.en;
        bus.req0_valid = v.v0; bus.req0_data = v.d0;
        bus.req1_valid = v.v1; bus.req1_data = v.d1;
        for (int i = 0; i < FRAME + 2; i++) begin
            sample();
            if (p_fs) begin
                check({tag, "/handshake"},
                      32'({underrun, bus.req0_ready, bus.req1_ready}),
                      32'({v.ur, v.r0, v.r1}));
                advance();
                sample();
                check({tag, "/serializer"},
                      32'({ser_load, ser_data, active_src, amp_sd}),
                      32'({v.ld, v.data, v.src, v.amp}));
                if (v.gap) check({tag, "/load_spacing"}, 32'(load_gap), 32'(FRAME));
                advance();
                return;
            end
            advance();
        end
        total++; bad++;
        $display("FAIL %s/timeout: no frame start within %0d cycles", tag, FRAME + 2);
    endtask

    task automatic go_to_bit(input int b);
        for (int i = 0; i < FRAME; i++) begin
            if ((m_t % FRAME) / DIV == b) return;
            sample();
            advance();
        end
    endtask

    task automatic reroll(input int s, input int pct, input bit fresh);
        bit nv;
        nv = (int'($urandom_range(0, 99)) < pct);
        if (s == 0) begin
            if (nv && (!bus.req0_valid || fresh)) bus.req0_data = 16'($urandom);
            bus.req0_valid = nv;
        end else begin
            if (nv && (!bus.req1_valid || fresh)) bus.req1_data = 16'($urandom);
            bus.req1_valid = nv;
        end
    endtask

    vec_t tbl[16];

    initial begin
        int ticks;
        tbl[0]  = mk(H, H, 16'hA5A5, L, 16'h0000, L, L, L, H, 16'h0000, L, H, L);
        tbl[1]  = mk(H, H, 16'hA5A5, L, 16'h0000, L, L, L, H, 16'h0000, L, H, H);
        tbl[2]  = mk(H, H, 16'hA5A5, L, 16'h0000, H, L, L, H, 16'hA5A5, L, H, H);
        tbl[3]  = mk(H, L, 16'h0000, H, 16'h2222, L, H, L, H, 16'h2222, H, H, H);
        tbl[4]  = mk(H, H, 16'h1111, H, 16'h2222, H, L, L, H, 16'h1111, L, H, H);
        tbl[5]  = mk(H, H, 16'h1111, H, 16'h2222, L, H, L, H, 16'h2222, H, H, H);
        tbl[6]  = mk(H, H, 16'h1111, H, 16'h2222, H, L, L, H, 16'h1111, L, H, H);
        tbl[7]  = mk(H, L, 16'h0000, L, 16'h0000, L, L, H, H, 16'h0000, L, H, H);
        tbl[8]  = mk(H, L, 16'h0000, L, 16'h0000, L, L, H, H, 16'h0000, L, H, H);
        tbl[9]  = mk(H, L, 16'h0000, L, 16'h0000, L, L, H, H, 16'h0000, L, L, H);
        tbl[10] = mk(H, L, 16'h0000, L, 16'h0000, L, L, L, L, 16'h0000, L, L, L);
        tbl[11] = mk(H, L, 16'h0000, H, 16'h3333, L, L, L, L, 16'h0000, L, H, L);
        tbl[12] = mk(H, L, 16'h0000, H, 16'h3333, L, L, L, H, 16'h0000, L, H, L);
        tbl[13] = mk(H, L, 16'h0000, H, 16'h3333, L, L, L, H, 16'h0000, L, H, H);
        tbl[14] = mk(H, L, 16'h0000, H, 16'h3333, L, H, L, H, 16'h3333, H, H, H);
        tbl[15] = mk(L, H, 16'h4444, L, 16'h0000, L, L, L, L, 16'h3333, H, L, L);

        model_reset();
        bus.req0_valid = 0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_data = '0;
        @(posedge clk);
        #1;

        // Reset state and idle OFF behaviour.
        check("reset_state", 32'({bit_tick, ser_load, ser_data, amp_sd, active_src, underrun,
                                  bus.req0_ready, bus.req1_ready}), 32'(0));
        cycles(2);
        reset = 1'b1;
        cycles(3);

        // Startup: amplifier on the clock after enable.
        enable = 1'b1; bus.req0_valid = 1'b1; bus.req0_data = 16'hA5A5;
        sample();
        advance();
        check("amp_on_after_enable", 32'(amp_sd), 32'(1));

        for (int i = 0; i < 16; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

        // Restart, then disable mid-frame with enable pulsed back.
        enable = 1'b1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        sample();
        advance();
        run_frame(mk(H, H, 16'h7777, L, 16'h0, L, L, L, H, 16'h0000, H, H, L), "rewake0");
        run_frame(mk(H, H, 16'h7777, L, 16'h0, L, L, L, H, 16'h0000, H, H, H), "rewake1");
        run_frame(mk(H, H, 16'h7777, L, 16'h0, H, L, L, H, 16'h7777, L, H, H), "rerun");
        go_to_bit(5);
        enable = 1'b0;
        cycles(2 * DIV);
        enable = 1'b1;
        run_frame(mk(H, H, 16'h8888, L, 16'h0, H, L, L, H, 16'h8888, L, H, H), "pulse_keep");

        // Disable at bit 5 held through the frame start.
        go_to_bit(5);
        enable = 1'b0;
        run_frame(mk(L, H, 16'h9999, L, 16'h0, L, L, L, L, 16'h8888, L, L, L), "disable");
        ticks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            sample();
            if (bit_tick === 1'b1) ticks++;
            advance();
        end
        check("ticks_after_off", 32'(ticks), 32'(0));

        // Asynchronous reset between clock edges during RUN.
        enable = 1'b1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        sample();
        advance();
        run_frame(mk(H, L, 16'h0, L, 16'h0000, L, L, L, H, 16'h0000, L, H, L), "arst_wake0");
        run_frame(mk(H, L, 16'h0, L, 16'h0000, L, L, L, H, 16'h0000, L, H, H), "arst_wake1");
        run_frame(mk(H, L, 16'h0, H, 16'hABCD, L, H, L, H, 16'hABCD, H, H, H), "arst_run");
        go_to_bit(7);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({bit_tick, ser_load, ser_data, amp_sd, active_src, underrun,
                   bus.req0_ready, bus.req1_ready}), 32'(0));
        model_reset();
        @(posedge clk);
        cyc++;
        #1;
        cycles(2);
        reset = 1'b1;
        enable = 1'b1;
        sample();
        advance();
        run_frame(mk(H, H, 16'h5555, H, 16'h6666, L, L, L, H, 16'h0000, L, H, L), "post_wake0");
        run_frame(mk(H, H, 16'h5555, H, 16'h6666, L, L, L, H, 16'h0000, L, H, H), "post_wake1");
        run_frame(mk(H, H, 16'h5555, H, 16'h6666, H, L, L, H, 16'h5555, L, H, H), "post_tie");

        // Randomized traffic, alternating busy and sparse epochs.
        for (int n = 0; n < 4000; n++) begin
            int pct;
            bit t0, t1;
            pct = ((n / 640) % 2 == 0) ? 75 : 8;
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) reroll(0, pct, 1'b0);
            if ($urandom_range(0, 15) == 0) reroll(1, pct, 1'b0);
            sample();
            t0 = p_r0;
            t1 = p_r1;
            advance();
            if (t0) reroll(0, pct, 1'b1);
            if (t1) reroll(1, pct, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
